alu_issue: RTL and testbench
============================

# alu_issue

Single-entry execute-issue stage that sits directly upstream of the 32-bit combinational ALU in the integer pipeline. Accepts decoded operations over a valid/ready handshake, resolves operands (register/immediate select, x0 zeroing, data forwarding), drives the ALU's A, B and ALU_OP inputs, and registers the ALU result plus destination register for the writeback stage. Provides back-pressure, pipeline flush and an issued-operation counter.

## Interface
- XLEN, 32, datapath width; matches ALU operand width
- CNT_W, 16, width of issued-operation counter

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard held result and refuse input this cycle
- in_valid_i  in  1  upstream op valid
- in_ready_o  out  1  stage can accept op this cycle
- alu_op_i  in  3  ALU operation code (000 add … 111 sra)
- rs1_addr_i, rs2_addr_i  in  5 each  source register indices
- rs1_data_i, rs2_data_i  in  XLEN each  register-file read data
- imm_i  in  XLEN  sign-extended immediate
- use_imm_i  in  1  1: B operand = imm_i; 0: B = resolved rs2
- rd_addr_i  in  5  destination register index
- alu_a_o, alu_b_o  out  XLEN each  ALU operands (combinational)
- alu_op_o  out  3  ALU operation (combinational, = alu_op_i)
- alu_result_i  in  XLEN  ALU combinational output
- wb_we_i  in  1  writeback stage writing register file
- wb_rd_i  in  5  writeback destination
- wb_data_i  in  XLEN  writeback data
- out_valid_o  out  1  held result valid
- out_ready_i  in  1  downstream accepts held result
- out_result_o  out  XLEN  registered ALU result
- out_rd_o  out  5  registered destination
- issue_count_o  out  CNT_W  count of accepted ops

## Operation
- Holding register: out_valid_o, out_result_o, out_rd_o.
- in_ready_o = !flush_i && (!out_valid_o || out_ready_i) && !hazard (hazard only without ALU_ISSUE_FWD_EN).
- Accept = in_valid_i && in_ready_o. On accept: out_result_o <= alu_result_i, out_rd_o <= rd_addr_i, out_valid_o <= 1, issue_count_o increments (wraps modulo 2^CNT_W).
- Result consumed (out_valid_o && out_ready_i) with no accept: out_valid_o <= 0. Consume and accept same cycle: new result loaded, out_valid_o stays 1.
- Operand resolution per source (rs1→A, rs2→B before immediate select), priority high→low:
  - index 0 → 0
  - out_valid_o && out_rd_o == index → out_result_o
  - wb_we_i && wb_rd_i == index → wb_data_i
  - else register-file data
- alu_b_o = use_imm_i ? imm_i : resolved rs2. For alu_op_i in {101,110,111}, alu_b_o[XLEN-1:5] forced to 0 (shift amount = low 5 bits).
- alu_a_o/alu_b_o/alu_op_o driven every cycle regardless of in_valid_i.
- flush_i: out_valid_o <= 0, no accept, counter unchanged; out_result_o/out_rd_o retain value.

## Timing
- Reset (rst_i high at edge): out_valid_o=0, out_result_o=0, out_rd_o=0, issue_count_o=0; rst_i dominates flush_i and accept. in_ready_o=1 the cycle after reset (given no flush).
- Latency: op accepted at edge N → out_valid_o=1 with result after edge N; throughput 1 op/cycle with out_ready_i held high.
- in_ready_o is combinational from out_valid_o, out_ready_i, flush_i and hazard; alu_* outputs are combinational from inputs and holding register.
- Back-pressure: out_valid_o && !out_ready_i → in_ready_o=0; held result stable until consumed or flushed.
- Flush and out_ready_i same cycle: flush wins; result dropped.
- Counter wrap: 0xFFFF + accept → 0x0000.

## Configuration
- ALU_ISSUE_FWD_EN defined: forwarding from holding register and writeback port as above; hazard=0.
- Undefined: forwarding paths removed (operands = register-file data or 0 for x0); hazard = in_valid_i && out_valid_o && out_rd_o≠0 && (out_rd_o==rs1_addr_i || (!use_imm_i && out_rd_o==rs2_addr_i)); stage stalls until the held result drains.

## Test plan
- Reset then rs1_data=5, rs2_data=7, op=000, rd=3, valid → next cycle out_valid_o=1, out_result_o=12, out_rd_o=3, issue_count_o=1.
- Back-to-back dependency: op1 rd=4 result 0x10; op2 rs1=4 (rf stale 0), imm=1, use_imm, op=000 → with FWD_EN result 0x11 in consecutive cycles; without, one-cycle stall then 0x01-path only after drain (in_ready_o=0 while hazard).
- out_ready_i=0 for 3 cycles with held result 0xAA → in_ready_o=0, out_result_o stays 0xAA; release → accepts next op.
- Shift: A=0x80000000, imm=0x00000021, op=110 → alu_b_o=1, out_result_o=0x40000000.
- flush_i with out_valid_o=1 and in_valid_i=1 → out_valid_o=0 next cycle, issue_count_o unchanged; rd=0 source reads 0 even when out_rd_o=0 holds nonzero data.
- Counter preset to 0xFFFF via 65535 accepts, one more accept → issue_count_o=0; rst_i mid-stream clears all outputs.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: single-entry issue stage in front of a combinational ALU; resolves operands, registers result/rd (1-cycle latency).
// Build option ALU_ISSUE_FWD_EN enables forwarding; without it, reads of the held destination stall until it drains.
module alu_issue #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       alu_op_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             use_imm_i,
    input  logic [4:0]       rd_addr_i,
    output logic [XLEN-1:0]  alu_a_o,
    output logic [XLEN-1:0]  alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [XLEN-1:0]  alu_result_i,
    input  logic             wb_we_i,
    input  logic [4:0]       wb_rd_i,
    input  logic [XLEN-1:0]  wb_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  out_result_o,
    output logic [4:0]       out_rd_o,
    output logic [CNT_W-1:0] issue_count_o
);

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_result;
    logic [4:0]       r_out_rd;
    logic [CNT_W-1:0] r_issue_count;

    logic             w_hazard;
    logic             w_ready;
    logic             w_accept;
    logic             w_consume;
    logic             w_is_shift;
    logic [XLEN-1:0]  w_rs1_val;
    logic [XLEN-1:0]  w_rs2_val;
    logic [XLEN-1:0]  w_b_sel;

    // Priority: x0, then the held (youngest) result, then writeback, then register file.
    always_comb begin
        w_rs1_val = rs1_data_i;
        if (rs1_addr_i == 5'd0)
            w_rs1_val = '0;
`ifdef ALU_ISSUE_FWD_EN
        else if (r_out_valid && (r_out_rd == rs1_addr_i))
            w_rs1_val = r_out_result;
        else if (wb_we_i && (wb_rd_i == rs1_addr_i))
            w_rs1_val = wb_data_i;
`endif
    end

    always_comb begin
        w_rs2_val = rs2_data_i;
        if (rs2_addr_i == 5'd0)
            w_rs2_val = '0;
`ifdef ALU_ISSUE_FWD_EN
        else if (r_out_valid && (r_out_rd == rs2_addr_i))
            w_rs2_val = r_out_result;
        else if (wb_we_i && (wb_rd_i == rs2_addr_i))
            w_rs2_val = wb_data_i;
`endif
    end

`ifdef ALU_ISSUE_FWD_EN
    assign w_hazard = 1'b0;
`else
    assign w_hazard = in_valid_i && r_out_valid && (r_out_rd != 5'd0) &&
                      ((r_out_rd == rs1_addr_i) || (!use_imm_i && (r_out_rd == rs2_addr_i)));

    logic w_unused_wb;
    assign w_unused_wb = ^{wb_we_i, wb_rd_i, wb_data_i};
`endif

    // Shift ops only use the low 5 bits of B as the shift amount.
    assign w_is_shift = (alu_op_i == 3'b101) || (alu_op_i == 3'b110) || (alu_op_i == 3'b111);

    always_comb begin
        w_b_sel = use_imm_i ? imm_i : w_rs2_val;
        if (w_is_shift)
            w_b_sel[XLEN-1:5] = '0;
    end

    assign w_ready   = !flush_i && (!r_out_valid || out_ready_i) && !w_hazard;
    assign w_accept  = in_valid_i && w_ready;
    assign w_consume = r_out_valid && out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_rd      <= '0;
            r_issue_count <= '0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= alu_result_i;
            r_out_rd      <= rd_addr_i;
            r_issue_count <= r_issue_count + CNT_W'(1);
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready_o    = w_ready;
    assign alu_a_o       = w_rs1_val;
    assign alu_b_o       = w_b_sel;
    assign alu_op_o      = alu_op_i;
    assign out_valid_o   = r_out_valid;
    assign out_result_o  = r_out_result;
    assign out_rd_o      = r_out_rd;
    assign issue_count_o = r_issue_count;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus random traffic against a behavioural model of the stage and ALU.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, use_imm, wb_we, out_ready;
    logic [2:0]  op;
    logic [4:0]  rs1, rs2, rd, wb_rd;
    logic [31:0] rs1_data, rs2_data, imm, wb_data;
    logic        in_ready, out_valid;
    logic [31:0] alu_a, alu_b, alu_result, out_result;
    logic [2:0]  alu_op_out;
    logic [4:0]  out_rd;
    logic [15:0] issue_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_known = 0;
    bit          m_valid;
    logic [31:0] m_result;
    logic [4:0]  m_rd;
    int unsigned m_count;

    always #5 clk = ~clk;

    alu_issue #(.XLEN(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .alu_op_i(op), .rs1_addr_i(rs1), .rs2_addr_i(rs2),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .imm_i(imm), .use_imm_i(use_imm), .rd_addr_i(rd),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op_out),
        .alu_result_i(alu_result),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_result_o(out_result), .out_rd_o(out_rd),
        .issue_count_o(issue_count)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b);
        case (f_op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return a >> b[4:0];
            default: return $signed(a) >>> b[4:0];
        endcase
    endfunction

    assign alu_result = alu_f(alu_op_out, alu_a, alu_b);

    // Value a source register should carry into the ALU.
    function automatic logic [31:0] src_val(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 5'd0) return 32'd0;
`ifdef ALU_ISSUE_FWD_EN
        if (m_valid && m_rd == idx) return m_result;
        if (wb_we && wb_rd == idx) return wb_data;
`endif
        return rf;
    endfunction

    function automatic logic [31:0] exp_a();
        return src_val(rs1, rs1_data);
    endfunction

    function automatic logic [31:0] exp_b();
        logic [31:0] b;
        b = use_imm ? imm : src_val(rs2, rs2_data);
        if (op >= 3'd5) b = b & 32'h0000_001F;
        return b;
    endfunction

    function automatic bit exp_ready();
        bit hz;
`ifdef ALU_ISSUE_FWD_EN
        hz = 0;
`else
        hz = in_valid && m_valid && (m_rd != 0) && ((m_rd == rs1) || (!use_imm && m_rd == rs2));
`endif
        return !flush && (!m_valid || out_ready) && !hz;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs already applied at the negedge.
    task automatic step();
        bit acc;
        logic [31:0] res;
        #1;
        acc = 0;
        if (m_known) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
            chk("alu_a", alu_a, exp_a());
            chk("alu_b", alu_b, exp_b());
            chk("alu_op", {29'd0, alu_op_out}, {29'd0, op});
            acc = in_valid && exp_ready();
        end
        res = alu_f(op, exp_a(), exp_b());
        @(posedge clk);
        if (rst) begin
            m_known = 1; m_valid = 0; m_result = 0; m_rd = 0; m_count = 0;
        end else if (m_known) begin
            if (flush) m_valid = 0;
            else if (acc) begin
                m_valid = 1; m_result = res; m_rd = rd; m_count = (m_count + 1) % 65536;
            end else if (m_valid && out_ready) m_valid = 0;
        end
        @(negedge clk);
        if (m_known) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("out_result", out_result, m_result);
            chk("out_rd", {27'd0, out_rd}, {27'd0, m_rd});
            chk("issue_count", {16'd0, issue_count}, m_count[31:0]);
        end
    endtask

    task automatic idle();
        rst = 0; flush = 0; in_valid = 0; use_imm = 0; wb_we = 0; out_ready = 1;
        op = 0; rs1 = 0; rs2 = 0; rd = 0; wb_rd = 0;
        rs1_data = 0; rs2_data = 0; imm = 0; wb_data = 0;
    endtask

    task automatic set_op(input logic [2:0] o, input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a2, input logic [31:0] d2,
                          input bit ui, input logic [31:0] im, input logic [4:0] dst);
        in_valid = 1; op = o; rs1 = a1; rs1_data = d1; rs2 = a2; rs2_data = d2;
        use_imm = ui; imm = im; rd = dst;
    endtask

    initial begin
        int unsigned c0;
        int unsigned n;
        idle();
        @(negedge clk);
        rst = 1;
        step();
        rst = 0;
        #1 chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // 5 + 7 -> x3
        set_op(3'd0, 5'd1, 32'd5, 5'd2, 32'd7, 0, 32'd0, 5'd3);
        step();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_result", out_result, 32'd12);
        chk("t1_rd", {27'd0, out_rd}, 32'd3);
        chk("t1_count", {16'd0, issue_count}, 32'd1);

        // Back-to-back dependency through x4
        set_op(3'd0, 5'd1, 32'h10, 5'd0, 32'd0, 1, 32'd0, 5'd4);
        step();
        chk("t2_first", out_result, 32'h10);
        set_op(3'd0, 5'd4, 32'd0, 5'd0, 32'd0, 1, 32'd1, 5'd5);
        #1;
`ifdef ALU_ISSUE_FWD_EN
        chk("t2_ready_fwd", {31'd0, in_ready}, 32'd1);
        step();
        chk("t2_result_fwd", out_result, 32'h11);
`else
        chk("t2_ready_hazard", {31'd0, in_ready}, 32'd0);
        step();
        chk("t2_drained", {31'd0, out_valid}, 32'd0);
        step();
        chk("t2_result_stale", out_result, 32'h01);
`endif

        // Back-pressure with 0xAA held
        set_op(3'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1, 32'hAA, 5'd6);
        step();
        set_op(3'd0, 5'd1, 32'd1, 5'd0, 32'd0, 1, 32'd1, 5'd7);
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_ready_bp", {31'd0, in_ready}, 32'd0);
            chk("t3_hold", out_result, 32'hAA);
        end
        out_ready = 1;
        step();
        chk("t3_release", out_result, 32'd2);

        // Shift amount masking
        set_op(3'd6, 5'd1, 32'h8000_0000, 5'd0, 32'd0, 1, 32'h21, 5'd8);
        #1 chk("t4_alu_b", alu_b, 32'd1);
        step();
        chk("t4_result", out_result, 32'h4000_0000);

        // Flush beats ready and accept
        c0 = m_count;
        set_op(3'd0, 5'd1, 32'd9, 5'd0, 32'd0, 1, 32'd9, 5'd9);
        flush = 1;
        step();
        flush = 0;
        chk("t5_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_flush_count", {16'd0, issue_count}, c0);
        chk("t5_flush_rd", {27'd0, out_rd}, 32'd8);

        // x0 never forwarded even with a held result for rd=0
        set_op(3'd0, 5'd1, 32'h55, 5'd0, 32'd0, 1, 32'd0, 5'd0);
        step();
        set_op(3'd0, 5'd0, 32'h1234, 5'd0, 32'h9999, 0, 32'd0, 5'd10);
        #1;
        chk("t5_x0_a", alu_a, 32'd0);
        chk("t5_x0_b", alu_b, 32'd0);
        step();

        // Random traffic, small register range to hit dependencies
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            op        = 3'($urandom_range(0, 7));
            rs1       = 5'($urandom_range(0, 3));
            rs2       = 5'($urandom_range(0, 3));
            rd        = 5'($urandom_range(0, 3));
            use_imm   = $urandom_range(0, 1) == 1;
            rs1_data  = $urandom;
            rs2_data  = $urandom;
            imm       = $urandom;
            wb_we     = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 3));
            wb_data   = $urandom;
            step();
        end

        // Counter wrap
        idle();
        set_op(3'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1, 32'd0, 5'd0);
        n = (65535 - m_count) % 65536;
        for (int unsigned i = 0; i < n; i++) step();
        chk("t6_count_max", {16'd0, issue_count}, 32'h0000_FFFF);
        step();
        chk("t6_count_wrap", {16'd0, issue_count}, 32'd0);

        // Reset mid-stream with a held result
        set_op(3'd0, 5'd1, 32'h77, 5'd0, 32'd0, 1, 32'd0, 5'd3);
        step();
        out_ready = 0;
        rst = 1;
        step();
        chk("t7_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t7_rst_result", out_result, 32'd0);
        chk("t7_rst_rd", {27'd0, out_rd}, 32'd0);
        chk("t7_rst_count", {16'd0, issue_count}, 32'd0);
        rst = 0;
        #1 chk("t7_ready", {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
